// File: rtl/pos_seq_pkg.sv
// Shared types for the running-light position sequencer.
// Optional end-of-travel dwell states appear only when POS_SEQ_DWELL_EN is defined.
package pos_seq_pkg;

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DN   = 2'b01,
      MODE_PP   = 2'b10,
      MODE_HOLD = 2'b11
   } mode_t;

`ifdef POS_SEQ_DWELL_EN
   typedef enum logic [1:0] {
      ST_UP        = 2'b00,
      ST_DOWN      = 2'b01,
      ST_DWELL_TOP = 2'b10,
      ST_DWELL_BOT = 2'b11
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_UP   = 2'b00,
      ST_DOWN = 2'b01
   } state_t;
`endif

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/pos_seq_tick.sv
// Prescaler: one-cycle tick every DIV enabled cycles; en low or clr restarts the count.
module tick_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] div_cnt;

   assign tick = en & (div_cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset || clr || !en || tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + CW'(1);
   end

endmodule

// File: rtl/pos_seq.sv
// Running-light position sequencer driving a one-hot decoder's binary index.
// Define POS_SEQ_DWELL_EN to hold each ping-pong end for an extra tick.
//
// state        | meaning
// -------------+---------------------------------------------------
// ST_UP        | travelling upward (dir = 0)
// ST_DOWN      | travelling downward (dir = 1)
// ST_DWELL_TOP | ping-pong parked at NPOS-1, reverses on next tick
// ST_DWELL_BOT | ping-pong parked at 0, reverses on next tick
module pos_seq
   import pos_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NPOS  = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] pos,
   output logic             step,
   output logic             dir
);

   localparam logic [WIDTH-1:0] POS_MAX = WIDTH'(NPOS - 1);

   logic             tick;
   state_t           state, state_nxt;
   logic [WIDTH-1:0] pos_nxt;
   logic             dir_nxt;

   // A load restarts the prescaler so the next tick lands a full period later.
   tick_div #(.DIV(DIV)) u_tick_div (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (load),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_UP;
         pos   <= '0;
         dir   <= DIR_UP;
         step  <= 1'b0;
      end else begin
         state <= state_nxt;
         pos   <= pos_nxt;
         dir   <= dir_nxt;
         step  <= (pos_nxt != pos);
      end
   end

   always_comb begin
      state_nxt = state;
      pos_nxt   = pos;
      dir_nxt   = dir;
      if (load) begin
         pos_nxt = (load_val > POS_MAX) ? POS_MAX : load_val;
`ifdef POS_SEQ_DWELL_EN
         if (state == ST_DWELL_TOP || state == ST_DWELL_BOT)
            state_nxt = (dir == DIR_DN) ? ST_DOWN : ST_UP;
`endif
      end else if (tick) begin
         if (pos > POS_MAX) begin
            pos_nxt = '0;
         end else begin
            case (mode_t'(mode))
               MODE_UP: begin
                  dir_nxt   = DIR_UP;
                  state_nxt = ST_UP;
                  pos_nxt   = (pos == POS_MAX) ? '0 : pos + WIDTH'(1);
               end
               MODE_DN: begin
                  dir_nxt   = DIR_DN;
                  state_nxt = ST_DOWN;
                  pos_nxt   = (pos == '0) ? POS_MAX : pos - WIDTH'(1);
               end
               MODE_PP: begin
                  case (state)
                     ST_UP: begin
                        if (pos == POS_MAX) begin
`ifdef POS_SEQ_DWELL_EN
                           state_nxt = ST_DWELL_TOP;
`else
                           state_nxt = ST_DOWN;
                           dir_nxt   = DIR_DN;
                           pos_nxt   = POS_MAX - WIDTH'(1);
`endif
                        end else begin
                           pos_nxt = pos + WIDTH'(1);
`ifdef POS_SEQ_DWELL_EN
                           if (pos_nxt == POS_MAX)
                              state_nxt = ST_DWELL_TOP;
`endif
                        end
                     end
                     ST_DOWN: begin
                        if (pos == '0) begin
`ifdef POS_SEQ_DWELL_EN
                           state_nxt = ST_DWELL_BOT;
`else
                           state_nxt = ST_UP;
                           dir_nxt   = DIR_UP;
                           pos_nxt   = WIDTH'(1);
`endif
                        end else begin
                           pos_nxt = pos - WIDTH'(1);
`ifdef POS_SEQ_DWELL_EN
                           if (pos_nxt == '0)
                              state_nxt = ST_DWELL_BOT;
`endif
                        end
                     end
`ifdef POS_SEQ_DWELL_EN
                     // Dwell exit only flips direction; the move happens a tick later.
                     ST_DWELL_TOP: begin
                        state_nxt = ST_DOWN;
                        dir_nxt   = DIR_DN;
                     end
                     ST_DWELL_BOT: begin
                        state_nxt = ST_UP;
                        dir_nxt   = DIR_UP;
                     end
`endif
                     default: state_nxt = ST_UP;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pos_seq.sv
// Scoreboard bench for pos_seq: a cycle model queues expected pos/dir/step per edge.
// Model follows POS_SEQ_DWELL_EN when defined.
module tb_pos_seq;

   localparam int WIDTH = 8;
   localparam int NPOS  = 8;
   localparam int DIV   = 4;
`ifdef POS_SEQ_DWELL_EN
   localparam bit DWELL = 1'b1;
`else
   localparam bit DWELL = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             en = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic             load = 1'b0;
   logic [WIDTH-1:0] load_val = '0;
   logic [WIDTH-1:0] pos;
   logic             step;
   logic             dir;

   always #5 clk = ~clk;

   pos_seq #(.WIDTH(WIDTH), .NPOS(NPOS), .DIV(DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .pos      (pos),
      .step     (step),
      .dir      (dir)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   typedef struct {
      int p;
      int d;
      int s;
   } exp_t;

   exp_t sb[$];
   int   m_pos = 0, m_dir = 0, m_cnt = 0, m_dwell = 0;

   task automatic model_step();
      exp_t e;
      int   np, nd, ndw;
      bit   tk;
      np  = m_pos;
      nd  = m_dir;
      ndw = m_dwell;
      if (reset) begin
         np = 0; nd = 0; ndw = 0; m_cnt = 0;
      end else if (load) begin
         np    = (int'(load_val) >= NPOS) ? NPOS - 1 : int'(load_val);
         ndw   = 0;
         m_cnt = 0;
      end else begin
         tk    = en && (m_cnt == DIV - 1);
         m_cnt = (!en || tk) ? 0 : m_cnt + 1;
         if (tk) begin
            case (mode)
               2'b00: begin nd = 0; ndw = 0; np = (m_pos == NPOS - 1) ? 0 : m_pos + 1; end
               2'b01: begin nd = 1; ndw = 0; np = (m_pos == 0) ? NPOS - 1 : m_pos - 1; end
               2'b10: begin
                  if (m_dwell != 0) begin
                     ndw = 0;
                     nd  = 1 - m_dir;
                  end else if (m_dir == 0) begin
                     if (m_pos == NPOS - 1) begin
                        if (DWELL) ndw = 1;
                        else begin nd = 1; np = NPOS - 2; end
                     end else begin
                        np = m_pos + 1;
                        if (DWELL && np == NPOS - 1) ndw = 1;
                     end
                  end else begin
                     if (m_pos == 0) begin
                        if (DWELL) ndw = 1;
                        else begin nd = 0; np = 1; end
                     end else begin
                        np = m_pos - 1;
                        if (DWELL && np == 0) ndw = 1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
      e.p = np;
      e.d = nd;
      e.s = reset ? 0 : int'(np != m_pos);
      sb.push_back(e);
      m_pos   = np;
      m_dir   = nd;
      m_dwell = ndw;
   endtask

   task automatic cycle();
      exp_t e;
      model_step();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("sb_pos", 32'(pos), e.p);
      check("sb_dir", 32'(dir), e.d);
      check("sb_step", 32'(step), e.s);
   endtask

   initial begin
      #1;
      reset = 1'b1;
      repeat (2) cycle();
      check("rst_pos", 32'(pos), 0);
      check("rst_step", 32'(step), 0);
      check("rst_dir", 32'(dir), 0);
      reset = 1'b0;
      repeat (3) cycle();

      // up-wrap, first step DIV cycles after en
      en = 1'b1; mode = 2'b00;
      repeat (DIV - 1) cycle();
      check("pre_first_step", 32'(step), 0);
      cycle();
      check("first_step", 32'(step), 1);
      check("first_pos", 32'(pos), 1);
      repeat (36) cycle();

      // ping-pong across both ends
      mode = 2'b10;
      repeat (100) cycle();

      // saturating load, then a no-change reload
      load = 1'b1; load_val = 8'd200;
      cycle();
      check("load_sat_pos", 32'(pos), 7);
      check("load_sat_step", 32'(step), 1);
      load_val = 8'd7;
      cycle();
      check("reload_step", 32'(step), 0);
      load = 1'b0;

      // load coinciding with a tick
      mode = 2'b00;
      for (int i = 0; i < 2 * DIV && m_cnt != DIV - 1; i++) cycle();
      check("align_tick", m_cnt, DIV - 1);
      load = 1'b1; load_val = 8'd3;
      cycle();
      load = 1'b0;
      check("ld_tick_pos", 32'(pos), 3);
      repeat (DIV - 1) cycle();
      check("ld_no_early_step", 32'(step), 0);
      cycle();
      check("ld_next_pos", 32'(pos), 4);
      check("ld_next_step", 32'(step), 1);

      // hold, then resume without re-phasing
      mode = 2'b11;
      repeat (20) cycle();
      check("hold_pos", 32'(pos), 4);
      mode = 2'b00;
      repeat (12) cycle();

      // reset mid-run at pos 5 moving down
      mode = 2'b01;
      for (int i = 0; i < 100 && !(m_pos == 5 && m_dir == 1); i++) cycle();
      check("reach5_pos", 32'(pos), 5);
      check("reach5_dir", 32'(dir), 1);
      reset = 1'b1; load = 1'b1; load_val = 8'd2;
      cycle();
      check("midrst_pos", 32'(pos), 0);
      check("midrst_dir", 32'(dir), 0);
      check("midrst_step", 32'(step), 0);
      reset = 1'b0; load = 1'b0;

      // random mix
      repeat (400) begin
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
         load     = ($urandom_range(0, 24) == 0);
         load_val = 8'($urandom_range(0, 255));
         reset    = ($urandom_range(0, 149) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
